// File: rtl/cloud_renderer.sv
// cloud_renderer
// Latches the cloud centre/half-extent once per frame (on frame_start) and
// answers per-pixel queries through a fixed 3-cycle pipeline:
//   S1  geometry (dx/dy, box hit) and sprite ROM address
//   S2  sprite ROM read (external ROM, 1-cycle latency)
//   Out cloud_on / color_idx / pix_valid registered
// Build option: define CLOUD_WRAP_EN to wrap the cloud horizontally modulo
// H_VISIBLE. Without it the cloud clips at both screen edges and H_VISIBLE
// has no role, so the parameter only exists in the wrapping build.

module cloud_renderer #(
`ifdef CLOUD_WRAP_EN
  parameter int H_VISIBLE = 640,
`endif
  parameter int SPR_BITS  = 6,
  parameter int CIDX_W    = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic [9:0]            CloudX,
  input  logic [9:0]            CloudY,
  input  logic [9:0]            CloudS,
  input  logic                  pix_req,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  output logic [2*SPR_BITS-1:0] rom_addr,
  input  logic [CIDX_W-1:0]     rom_data,
  output logic                  pix_valid,
  output logic                  cloud_on,
  output logic [CIDX_W-1:0]     color_idx,
  output logic                  armed
);

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   armed_q, armed_d;

  // Per-frame shadow copies of the motion block outputs
  logic [9:0] cloud_x_q, cloud_x_d;
  logic [9:0] cloud_y_q, cloud_y_d;
  logic [9:0] cloud_s_q, cloud_s_d;

  // Pipeline registers
  logic [2*SPR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic                  hit1_q, hit1_d;
  logic                  v1_q, v1_d;
  logic                  hit2_q, hit2_d;
  logic                  v2_q, v2_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  cloud_on_q, cloud_on_d;
  logic [CIDX_W-1:0]     color_idx_q, color_idx_d;

  // S1 geometry, 12-bit signed so negative offsets survive
  logic signed [11:0] dx_s;
  logic signed [11:0] dy_s;
  logic signed [11:0] two_s_s;
  logic               h_hit_s;
  logic               v_hit_s;
  logic               hit_s;

`ifdef CLOUD_WRAP_EN
  localparam logic signed [11:0] HV  = 12'(H_VISIBLE);
  localparam logic signed [11:0] HV2 = 12'(2 * H_VISIBLE);
  localparam logic signed [11:0] HV3 = 12'(3 * H_VISIBLE);
  logic [9:0]         x_red_s;
  logic signed [11:0] x_raw_s;
`endif

  // FSM state register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= WAIT_FRAME;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // FSM next state: first frame_start arms the renderer for good
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) begin
          state_d = ACTIVE;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      ACTIVE:  state_d = ACTIVE;
      default: state_d = WAIT_FRAME;
    endcase
  end

  // FSM output: armed is registered alongside the state
  always_comb begin
    armed_d = (state_d == ACTIVE);
  end

  // Shadow load on frame_start; a same-cycle pixel still sees the old values
  always_comb begin
    if (frame_start) begin
      cloud_x_d = CloudX;
      cloud_y_d = CloudY;
      cloud_s_d = CloudS;
    end else begin
      cloud_x_d = cloud_x_q;
      cloud_y_d = cloud_y_q;
      cloud_s_d = cloud_s_q;
    end
  end

  // S1 geometry: box offsets and hit test against the shadowed cloud
  always_comb begin
    dy_s    = $signed({2'b00, DrawY}) - $signed({2'b00, cloud_y_q})
            + $signed({2'b00, cloud_s_q});
    two_s_s = $signed({1'b0, cloud_s_q, 1'b0});
    v_hit_s = (dy_s >= 12'sd0) && (dy_s <= two_s_s);
`ifdef CLOUD_WRAP_EN
    // Bring an off-screen centre back into 0..H_VISIBLE-1 first
    if (cloud_x_q >= 10'(H_VISIBLE)) begin
      x_red_s = cloud_x_q - 10'(H_VISIBLE);
    end else begin
      x_red_s = cloud_x_q;
    end
    x_raw_s = $signed({2'b00, DrawX}) - $signed({2'b00, x_red_s})
            + $signed({2'b00, cloud_s_q});
    // Raw offset spans -(H-1)..2046, so one add or up to three subtracts
    if (x_raw_s < 12'sd0) begin
      dx_s = x_raw_s + HV;
    end else if (x_raw_s >= HV3) begin
      dx_s = x_raw_s - HV3;
    end else if (x_raw_s >= HV2) begin
      dx_s = x_raw_s - HV2;
    end else if (x_raw_s >= HV) begin
      dx_s = x_raw_s - HV;
    end else begin
      dx_s = x_raw_s;
    end
    // A box at least as wide as the screen covers every column
    h_hit_s = (dx_s <= two_s_s) || (two_s_s >= (HV - 12'sd1));
`else
    dx_s    = $signed({2'b00, DrawX}) - $signed({2'b00, cloud_x_q})
            + $signed({2'b00, cloud_s_q});
    h_hit_s = (dx_s >= 12'sd0) && (dx_s <= two_s_s);
`endif
    hit_s = h_hit_s & v_hit_s & armed_q;
  end

  // Pipeline next values: S1 capture, S2 pass-through, output merge with ROM
  always_comb begin
    if (pix_req) begin
      // Sprite tiles when the box is wider than the sprite: low bits wrap
      rom_addr_d = {dy_s[SPR_BITS-1:0], dx_s[SPR_BITS-1:0]};
    end else begin
      rom_addr_d = rom_addr_q;
    end
    hit1_d      = pix_req & hit_s;
    v1_d        = pix_req;
    hit2_d      = hit1_q;
    v2_d        = v1_q;
    pix_valid_d = v2_q;
    cloud_on_d  = hit2_q & (rom_data != {CIDX_W{1'b0}});
    if (cloud_on_d) begin
      color_idx_d = rom_data;
    end else begin
      color_idx_d = {CIDX_W{1'b0}};
    end
  end

  // Datapath registers; reset drops every in-flight request
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cloud_x_q   <= 10'd0;
      cloud_y_q   <= 10'd0;
      cloud_s_q   <= 10'd0;
      rom_addr_q  <= {(2*SPR_BITS){1'b0}};
      hit1_q      <= 1'b0;
      v1_q        <= 1'b0;
      hit2_q      <= 1'b0;
      v2_q        <= 1'b0;
      pix_valid_q <= 1'b0;
      cloud_on_q  <= 1'b0;
      color_idx_q <= {CIDX_W{1'b0}};
    end else begin
      cloud_x_q   <= cloud_x_d;
      cloud_y_q   <= cloud_y_d;
      cloud_s_q   <= cloud_s_d;
      rom_addr_q  <= rom_addr_d;
      hit1_q      <= hit1_d;
      v1_q        <= v1_d;
      hit2_q      <= hit2_d;
      v2_q        <= v2_d;
      pix_valid_q <= pix_valid_d;
      cloud_on_q  <= cloud_on_d;
      color_idx_q <= color_idx_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_valid = pix_valid_q;
  assign cloud_on  = cloud_on_q;
  assign color_idx = color_idx_q;
  assign armed     = armed_q;

endmodule
